// File: rtl/image_buffer_writer_if.sv
// image_buffer_writer_if: pixel stream in, RAM write port and status out.
interface image_buffer_writer_if #(parameter int p_addr_width = 16);
  logic                    start;
  logic                    pix_valid;
  logic                    pix_ready;
  logic                    pix_sof;
  logic [7:0]              pix_R;
  logic [7:0]              pix_G;
  logic [7:0]              pix_B;
  logic                    wr_en;
  logic [p_addr_width-1:0] wr_addr;
  logic [23:0]             wr_data;
  logic                    busy;
  logic                    frame_done;
  logic                    sync_err;
  modport master (
    output start, pix_valid, pix_sof, pix_R, pix_G, pix_B,
    input  pix_ready, wr_en, wr_addr, wr_data, busy, frame_done, sync_err
  );
  modport slave (
    input  start, pix_valid, pix_sof, pix_R, pix_G, pix_B,
    output pix_ready, wr_en, wr_addr, wr_data, busy, frame_done, sync_err
  );
endinterface

// File: rtl/image_buffer_writer.sv
// image_buffer_writer: captures one raster RGB frame per start into the image RAM write port.
module image_buffer_writer #(
  parameter int p_image_width  = 80,
  parameter int p_image_height = 480,
  parameter int p_addr_width   = 16
) (
  input logic                  clk,
  input logic                  reset,
  image_buffer_writer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;
  localparam logic [p_addr_width-1:0] lc  = p_addr_width'(p_image_width - 1);
  localparam logic [p_addr_width-1:0] lr  = p_addr_width'(p_image_height - 1);
  localparam logic [p_addr_width-1:0] one = p_addr_width'(1);
  state_t                  state, state_n;
  logic [p_addr_width-1:0] col, row, addr, col_n, row_n, addr_n;
  logic [p_addr_width-1:0] wcol, wrow, waddr;
  logic [p_addr_width-1:0] wr_addr, wr_addr_n;
  logic [23:0]             wr_data, wr_data_n;
  logic                    wr_en, wr_en_n, sync_err, sync_err_n, take, wlast;
  assign bus.pix_ready  = state == S_WAIT || state == S_WRITE;
  assign bus.busy       = state != S_IDLE;
  assign bus.frame_done = state == S_DONE;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = wr_data;
  assign bus.sync_err   = sync_err;
  // A sof pixel always lands at (0,0); otherwise the pixel lands at the current counters.
  always_comb begin
    take       = bus.pix_valid && bus.pix_ready && (bus.pix_sof || state == S_WRITE);
    wcol       = bus.pix_sof ? '0 : col;
    wrow       = bus.pix_sof ? '0 : row;
    waddr      = bus.pix_sof ? '0 : addr;
    wlast      = wcol == lc && wrow == lr;
    state_n    = state;
    col_n      = col;
    row_n      = row;
    addr_n     = addr;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    sync_err_n = 1'b0;
    if (state == S_IDLE && bus.start) begin
      state_n = S_WAIT;
      col_n   = '0;
      row_n   = '0;
      addr_n  = '0;
    end
    if (state == S_DONE) state_n = S_IDLE;
    if (take) begin
      wr_en_n    = 1'b1;
      wr_addr_n  = waddr;
      wr_data_n  = {bus.pix_R, bus.pix_G, bus.pix_B};
      sync_err_n = bus.pix_sof && state == S_WRITE;
      state_n    = wlast ? S_DONE : S_WRITE;
      col_n      = (wlast || wcol == lc) ? '0 : wcol + one;
      row_n      = wlast ? '0 : (wcol == lc ? wrow + one : wrow);
      addr_n     = wlast ? '0 : waddr + one;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      row      <= row_n;
      addr     <= addr_n;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      sync_err <= sync_err_n;
    end
  end
endmodule

// File: tb/tb_image_buffer_writer.sv
// tb_image_buffer_writer: directed checks of a 4x2 writer and a default 80x480 writer.
module tb_image_buffer_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  image_buffer_writer_if #(.p_addr_width(16)) a ();
  image_buffer_writer_if #(.p_addr_width(16)) b ();
  image_buffer_writer #(.p_image_width(4), .p_image_height(2), .p_addr_width(16)) dut_small (
    .clk(clk), .reset(reset), .bus(a.slave));
  image_buffer_writer dut_full (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_pix(input logic v, input logic s, input logic [23:0] d);
    a.pix_valid = v;
    a.pix_sof   = s;
    {a.pix_R, a.pix_G, a.pix_B} = d;
  endtask
  task automatic start_small;
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    n_vec++;
    if ({a.pix_ready, a.busy} !== 2'b11) begin
      n_err++;
      $display("FAIL start_ready got=%b want=11", {a.pix_ready, a.busy});
    end
  endtask
  task automatic test_reset;
    set_pix(1'b1, 1'b0, 24'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if ({a.pix_ready, a.wr_en, a.wr_addr, a.wr_data, a.busy, a.frame_done, a.sync_err} !== '0) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d ready=%b wr_en=%b addr=%0d data=%h busy=%b done=%b err=%b want all 0",
                 i, a.pix_ready, a.wr_en, a.wr_addr, a.wr_data, a.busy, a.frame_done, a.sync_err);
      end
    end
    set_pix(1'b0, 1'b0, 24'h0);
  endtask
  task automatic test_full_frame;
    start_small();
    for (int i = 0; i < 8; i++) begin
      set_pix(1'b1, i == 0, 24'(i + 1));
      step();
      n_vec++;
      if ({a.wr_en, a.wr_addr, a.wr_data, a.frame_done, a.sync_err} !== {1'b1, 16'(i), 24'(i + 1), i == 7, 1'b0}) begin
        n_err++;
        $display("FAIL full_write i=%0d got en=%b addr=%0d data=%h done=%b err=%b want en=1 addr=%0d data=%h done=%b err=0",
                 i, a.wr_en, a.wr_addr, a.wr_data, a.frame_done, a.sync_err, i, 24'(i + 1), i == 7);
      end
    end
    step();
    set_pix(1'b0, 1'b0, 24'h0);
    n_vec++;
    if ({a.pix_ready, a.wr_en, a.busy, a.frame_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL full_after got ready/en/busy/done=%b want 0000", {a.pix_ready, a.wr_en, a.busy, a.frame_done});
    end
  endtask
  task automatic test_discard_stall;
    start_small();
    for (int i = 0; i < 3; i++) begin
      set_pix(1'b1, 1'b0, 24'hAA0000 + 24'(i));
      step();
      n_vec++;
      if ({a.wr_en, a.pix_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL discard i=%0d got en/ready=%b want 01", i, {a.wr_en, a.pix_ready});
      end
    end
    for (int k = 0; k < 16; k++) begin
      automatic int p = k / 2;
      automatic logic v = (k % 2) == 0;
      set_pix(v, v && p == 0, 24'h10 + 24'(p));
      step();
      n_vec++;
      if (v && {a.wr_en, a.wr_addr, a.wr_data, a.frame_done} !== {1'b1, 16'(p), 24'h10 + 24'(p), p == 7}) begin
        n_err++;
        $display("FAIL stall_write k=%0d got en=%b addr=%0d data=%h done=%b want en=1 addr=%0d data=%h done=%b",
                 k, a.wr_en, a.wr_addr, a.wr_data, a.frame_done, p, 24'h10 + 24'(p), p == 7);
      end
      if (!v && a.wr_en !== 1'b0) begin
        n_err++;
        $display("FAIL stall_gap k=%0d got en=%b want 0", k, a.wr_en);
      end
    end
    set_pix(1'b0, 1'b0, 24'h0);
    n_vec++;
    if (a.pix_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_after got ready=%b want 0", a.pix_ready);
    end
  endtask
  task automatic test_resync;
    start_small();
    for (int i = 0; i < 13; i++) begin
      automatic int ea = i < 5 ? i : i - 5;
      set_pix(1'b1, i == 0 || i == 5, 24'h20 + 24'(i));
      step();
      n_vec++;
      if ({a.wr_en, a.wr_addr, a.wr_data, a.sync_err, a.frame_done} !== {1'b1, 16'(ea), 24'h20 + 24'(i), i == 5, i == 12}) begin
        n_err++;
        $display("FAIL resync i=%0d got en=%b addr=%0d data=%h err=%b done=%b want en=1 addr=%0d data=%h err=%b done=%b",
                 i, a.wr_en, a.wr_addr, a.wr_data, a.sync_err, a.frame_done, ea, 24'h20 + 24'(i), i == 5, i == 12);
      end
    end
    set_pix(1'b0, 1'b0, 24'h0);
    step();
  endtask
  task automatic test_reset_mid;
    start_small();
    for (int i = 0; i < 4; i++) begin
      set_pix(1'b1, i == 0, 24'h30 + 24'(i));
      step();
    end
    n_vec++;
    if ({a.wr_en, a.wr_addr} !== {1'b1, 16'd3}) begin
      n_err++;
      $display("FAIL mid_pre got en=%b addr=%0d want en=1 addr=3", a.wr_en, a.wr_addr);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({a.wr_en, a.wr_addr, a.wr_data, a.pix_ready, a.busy} !== '0) begin
      n_err++;
      $display("FAIL mid_async got en=%b addr=%0d data=%h ready=%b busy=%b want all 0",
               a.wr_en, a.wr_addr, a.wr_data, a.pix_ready, a.busy);
    end
    step();
    reset = 1'b0;
    step();
    n_vec++;
    if ({a.wr_en, a.pix_ready, a.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_idle got en/ready/busy=%b want 000", {a.wr_en, a.pix_ready, a.busy});
    end
    set_pix(1'b0, 1'b0, 24'h0);
    start_small();
    for (int i = 0; i < 8; i++) begin
      set_pix(1'b1, i == 0, 24'h40 + 24'(i));
      step();
      n_vec++;
      if ({a.wr_en, a.wr_addr, a.wr_data, a.frame_done} !== {1'b1, 16'(i), 24'h40 + 24'(i), i == 7}) begin
        n_err++;
        $display("FAIL mid_restart i=%0d got en=%b addr=%0d data=%h done=%b want en=1 addr=%0d data=%h done=%b",
                 i, a.wr_en, a.wr_addr, a.wr_data, a.frame_done, i, 24'h40 + 24'(i), i == 7);
      end
    end
    set_pix(1'b0, 1'b0, 24'h0);
    step();
  endtask
  task automatic test_default_params;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    for (int i = 0; i < 38400; i++) begin
      b.pix_valid = 1'b1;
      b.pix_sof   = i == 0;
      {b.pix_R, b.pix_G, b.pix_B} = 24'(i);
      step();
      n_vec++;
      if ({b.wr_en, b.wr_addr, b.wr_data, b.frame_done} !== {1'b1, 16'(i), 24'(i), i == 38399}) begin
        n_err++;
        $display("FAIL default i=%0d got en=%b addr=%0d data=%h done=%b want en=1 addr=%0d done=%b",
                 i, b.wr_en, b.wr_addr, b.wr_data, b.frame_done, i, i == 38399);
      end
    end
    b.pix_valid = 1'b0;
    b.pix_sof   = 1'b0;
    step();
    n_vec++;
    if ({b.pix_ready, b.busy, b.wr_en} !== 3'b000) begin
      n_err++;
      $display("FAIL default_after got ready/busy/en=%b want 000", {b.pix_ready, b.busy, b.wr_en});
    end
  endtask
  initial begin
    a.start = 1'b0;
    set_pix(1'b0, 1'b0, 24'h0);
    b.start = 1'b0;
    b.pix_valid = 1'b0;
    b.pix_sof = 1'b0;
    {b.pix_R, b.pix_G, b.pix_B} = 24'h0;
    test_reset();
    test_full_frame();
    test_discard_stall();
    test_resync();
    test_reset_mid();
    test_default_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/image_buffer_writer.md
# image_buffer_writer

Write-side counterpart to the image ROM/RAM readers in the VGA overlay path. Accepts a raster-ordered RGB pixel stream over a valid/ready handshake, computes the linear address `x + p_image_width*y` with counters, and drives the write port of the dual-port image RAM. The display-side readers then fetch pixels from that RAM. One frame is captured per `start` command. The block resynchronises on a start-of-frame marker.

## Interface
Parameters:
- `p_image_width`, 80, pixels per row.
- `p_image_height`, 480, rows per frame.
- `p_addr_width`, 16, RAM address width. Must satisfy `p_image_width*p_image_height <= 2**p_addr_width`.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to capture one frame. Honoured only in IDLE.
- `pix_valid`  in  1  source has a pixel.
- `pix_ready`  out  1  block accepts a pixel this cycle.
- `pix_sof`  in  1  qualifies the current pixel as pixel (0,0) of a frame.
- `pix_R`, `pix_G`, `pix_B`  in  8 each  pixel colour.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  p_addr_width  RAM write address.
- `wr_data`  out  24  `{R,G,B}` write data.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when a full frame has been written.
- `sync_err`  out  1  one-cycle pulse when `pix_sof` arrives mid-frame.

## Operation
- Accept means `pix_valid && pix_ready` at a rising edge. Non-accepted cycles change nothing.
- Counters:
  - `col` runs 0..p_image_width-1.
  - `row` runs 0..p_image_height-1.
  - `addr` is incremented by 1 per written pixel. There is no multiplier, and `addr` always equals `col + p_image_width*row`.
  - When `col` wraps to 0, `row` increments.
- States:
  - IDLE:
    - `pix_ready=0`, `busy=0`.
    - `start=1` → WAIT_SOF, with counters cleared.
  - WAIT_SOF:
    - `pix_ready=1`.
    - An accepted pixel with `pix_sof=0` is dropped: no write.
    - An accepted pixel with `pix_sof=1` is written at address 0. Then col←1 (or row←1, col←0 if width=1), addr←1, → WRITE.
  - WRITE:
    - `pix_ready=1`.
    - Each accepted pixel is written at the current `addr`, then counters advance.
    - If `pix_sof=1` on an accepted pixel: write it at address 0, set counters to the (0,0)-successor, and pulse `sync_err`. The frame restarts and the already-written pixels are not rewound.
    - Acceptance of pixel (p_image_width-1, p_image_height-1) → DONE.
  - DONE:
    - `pix_ready=0`.
    - `frame_done=1` for this single cycle.
    - → IDLE on the next edge.
- `start` outside IDLE is ignored. `start` and an accepted pixel in the same IDLE cycle cannot both happen, because `pix_ready=0` in IDLE.
- If the single pixel in a 1×1 frame is accepted with sof in WAIT_SOF → DONE directly.

## Timing
- Reset values: state IDLE, col=row=addr=0.
  - Outputs: `pix_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `frame_done=0`, `sync_err=0`.
- `wr_en`, `wr_addr`, `wr_data` and `sync_err` are registered. They are valid in the cycle after the accepting edge (latency 1). `wr_en` is high for exactly one cycle per written pixel.
- `pix_ready` and `busy` are decoded from the registered state (Moore). There is no combinational path from `pix_valid` to `pix_ready`.
- Sustained throughput is 1 pixel/clock in WAIT_SOF and WRITE.
- `frame_done` is high in the same cycle as the `wr_en` for the final pixel.
- `reset` asserted mid-frame:
  - Immediately forces IDLE and clears all outputs, including a pending `wr_en`.
  - Partial frame contents in RAM are left as written.
- Address never exceeds `p_image_width*p_image_height-1`. No wrap occurs inside WRITE.

## Test plan
Bench parameters are W=4, H=2 unless noted.

- **Reset then idle.** Hold `pix_valid=1`, no `start` → `pix_ready=0`, `wr_en` never asserts, all outputs 0.
- **Full frame, back-to-back.**
  - Stimulus: `start`, then 8 pixels with `pix_valid` held high, sof on the first, data 0x000001..0x000008.
  - Required: writes at addr 0..7 with matching data on consecutive cycles. `frame_done` pulses alongside the addr-7 write. `pix_ready=0` afterwards.
- **Pre-sof discard and stalls.**
  - Stimulus: 3 non-sof pixels in WAIT_SOF, then a frame with `pix_valid` toggling 1/0.
  - Required: the first 3 pixels produce no writes. Addresses remain sequential 0..7 with gaps only on stall cycles.
- **Mid-frame resync.**
  - Stimulus: sof on pixel index 5 of the stream.
  - Required: writes at 0,1,2,3,4 then 0. `sync_err` pulses with the second addr-0 write. `frame_done` follows after 7 further pixels.
- **Reset mid-frame.**
  - Stimulus: assert `reset` after the addr-3 accept.
  - Required: `wr_en` drops asynchronously and no addr-3 write is completed after reset. The block returns to IDLE, and a fresh `start` captures from addr 0.
- **Default parameters (80×480).** A full frame → last write at addr 38399. `frame_done` occurs exactly 38400 accepts after sof.
